// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared FSM state encoding and width helpers for set_assoc_cache
package cache_pkg;

  // Miss-handling FSM states
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WRITEBACK = 2'd1;
  localparam logic [1:0] ST_REFILL    = 2'd2;
  localparam logic [1:0] ST_RESPOND   = 2'd3;

  function automatic int log2c(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int idx_w(input int sets);
    return log2c(sets);
  endfunction

  // Tag is everything above the index and the two byte-offset bits
  function automatic int tag_w(input int addr_w, input int sets);
    return addr_w - log2c(sets) - 2;
  endfunction

  // A direct-mapped cache still carries a 1-bit way number so vectors stay legal
  function automatic int way_w(input int ways);
    return (ways <= 1) ? 1 : log2c(ways);
  endfunction

endpackage

// File: rtl/cache_way.sv
// rtl/cache_way.sv - one way of the cache: tag/valid/dirty/data arrays, hit compare, write port
module cache_way
  import cache_pkg::*;
#(
  parameter int SETS   = 256,
  parameter int TAG_W  = 22,
  parameter int DATA_W = 32,
  parameter int IDX_W  = idx_w(SETS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [TAG_W-1:0]  rd_tag,
  output logic              hit,
  output logic              valid,
  output logic              dirty,
  output logic [TAG_W-1:0]  tag,
  output logic [DATA_W-1:0] data,
  input  logic              wr_en,
  input  logic              wr_dirty,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data
);

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [DATA_W-1:0] data_mem [SETS];

  // Status bits are reset so every line starts invalid; any write installs a valid line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
      dirty_q[wr_idx] <= wr_dirty;
    end
  end

  // Tag and data storage is not reset; valid_q guards its use
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign valid = valid_q[rd_idx];
  assign dirty = dirty_q[rd_idx];
  assign tag   = tag_mem[rd_idx];
  assign data  = data_mem[rd_idx];
  assign hit   = valid && (tag_mem[rd_idx] == rd_tag);

endmodule

// File: rtl/set_assoc_cache.sv
// rtl/set_assoc_cache.sv - N-way write-back write-allocate cache; CACHE_PERF_CNT_EN adds perf counters
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int WAYS   = 4,
  parameter int SETS   = 256,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              rc_Valid,
  input  logic              rc_RW,
  input  logic [ADDR_W-1:0] rc_Addr,
  input  logic [DATA_W-1:0] rc_WriteData,
  output logic              rc_Ready,
  output logic [DATA_W-1:0] rc_ReadData,
  output logic              cm_ReadValid,
  output logic [ADDR_W-1:0] cm_ReadAddr,
  input  logic              cm_ReadReady,
  input  logic [DATA_W-1:0] cm_ReadData,
  output logic              cm_WriteValid,
  output logic [ADDR_W-1:0] cm_WriteAddr,
  output logic [DATA_W-1:0] cm_WriteData,
  input  logic              cm_WriteReady
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]       perf_Hits,
  output logic [31:0]       perf_Misses,
  output logic [31:0]       perf_Writebacks
`endif
);

  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(ADDR_W, SETS);
  localparam int WAY_W = way_w(WAYS);

  logic [1:0]        state;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_rw;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] resp_data;
  logic [WAY_W-1:0]  lat_way;
  logic [WAY_W-1:0]  rr_ptr [SETS];

  logic [IDX_W-1:0]  req_idx, lat_idx, look_idx;
  logic [TAG_W-1:0]  req_tag, lat_tag, look_tag;
  logic [WAYS-1:0]   hit, way_valid, way_dirty, wr_en_vec;
  logic [TAG_W-1:0]  way_tag  [WAYS];
  logic [DATA_W-1:0] way_data [WAYS];
  logic [WAY_W-1:0]  hit_way, vict, wr_sel;
  logic              hit_any, all_valid, vict_dirty;
  logic              req, req_hit, req_miss, miss_install, wr_en, wr_dirty;
  logic [TAG_W-1:0]  wr_tag;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        unused_addr_bits;

  assign unused_addr_bits = rc_Addr[1:0];
  assign req_idx  = rc_Addr[IDX_W+1:2];
  assign req_tag  = rc_Addr[ADDR_W-1:IDX_W+2];
  assign lat_idx  = lat_addr[IDX_W+1:2];
  assign lat_tag  = lat_addr[ADDR_W-1:IDX_W+2];
  // Outside IDLE the arrays are looked up at the latched miss set
  assign look_idx = (state == ST_IDLE) ? req_idx : lat_idx;
  assign look_tag = (state == ST_IDLE) ? req_tag : lat_tag;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_way #(
      .SETS  (SETS),
      .TAG_W (TAG_W),
      .DATA_W(DATA_W),
      .IDX_W (IDX_W)
    ) u_way (
      .clk     (CLK),
      .rst_n   (Reset_n),
      .rd_idx  (look_idx),
      .rd_tag  (look_tag),
      .hit     (hit[w]),
      .valid   (way_valid[w]),
      .dirty   (way_dirty[w]),
      .tag     (way_tag[w]),
      .data    (way_data[w]),
      .wr_en   (wr_en_vec[w]),
      .wr_dirty(wr_dirty),
      .wr_idx  (look_idx),
      .wr_tag  (wr_tag),
      .wr_data (wr_data)
    );
  end

  // Hit way and victim selection: lowest invalid way first, else the set's round-robin pointer
  always_comb begin
    hit_any   = |hit;
    all_valid = &way_valid;
    hit_way   = '0;
    vict      = rr_ptr[look_idx];
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit[i])        hit_way = WAY_W'(i);
      if (!way_valid[i]) vict    = WAY_W'(i);
    end
    vict_dirty = way_valid[vict] && way_dirty[vict];
  end

  assign req          = (state == ST_IDLE) && rc_Valid;
  assign req_hit      = req && hit_any;
  assign req_miss     = req && !hit_any;
  assign miss_install = req_miss && !vict_dirty && rc_RW;

  // Single write port into the ways: store hit, clean write-miss install, refill, late write install
  always_comb begin
    wr_en    = 1'b0;
    wr_sel   = hit_way;
    wr_tag   = req_tag;
    wr_data  = rc_WriteData;
    wr_dirty = 1'b1;
    if (req_hit && rc_RW) begin
      wr_en = 1'b1;
    end else if (miss_install) begin
      wr_en  = 1'b1;
      wr_sel = vict;
    end else if ((state == ST_REFILL) && cm_ReadReady) begin
      wr_en    = 1'b1;
      wr_sel   = lat_way;
      wr_tag   = lat_tag;
      wr_data  = cm_ReadData;
      wr_dirty = 1'b0;
    end else if ((state == ST_RESPOND) && lat_rw) begin
      wr_en   = 1'b1;
      wr_sel  = lat_way;
      wr_tag  = lat_tag;
      wr_data = lat_wdata;
    end
    wr_en_vec         = '0;
    wr_en_vec[wr_sel] = wr_en;
  end

  // Miss FSM; the pointer advances as soon as a miss commits to filling a full set
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= ST_IDLE;
      lat_addr  <= '0;
      lat_rw    <= 1'b0;
      lat_wdata <= '0;
      lat_way   <= '0;
      resp_data <= '0;
      for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_miss) begin
            lat_addr  <= {rc_Addr[ADDR_W-1:2], 2'b00};
            lat_rw    <= rc_RW;
            lat_wdata <= rc_WriteData;
            lat_way   <= vict;
            if (all_valid)
              rr_ptr[look_idx] <= (rr_ptr[look_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_ptr[look_idx] + 1'b1;
            if (vict_dirty)  state <= ST_WRITEBACK;
            else if (!rc_RW) state <= ST_REFILL;
          end
        end
        ST_WRITEBACK: if (cm_WriteReady) state <= lat_rw ? ST_RESPOND : ST_REFILL;
        ST_REFILL: begin
          if (cm_ReadReady) begin
            resp_data <= cm_ReadData;
            state     <= ST_RESPOND;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rc_Ready      = Reset_n && (req_hit || miss_install || (state == ST_RESPOND));
  assign rc_ReadData   = (req_hit && !rc_RW) ? way_data[hit_way] :
                         ((state == ST_RESPOND) && !lat_rw) ? resp_data : '0;
  assign cm_ReadValid  = (state == ST_REFILL);
  assign cm_ReadAddr   = cm_ReadValid ? lat_addr : '0;
  assign cm_WriteValid = (state == ST_WRITEBACK);
  assign cm_WriteAddr  = cm_WriteValid ? {way_tag[lat_way], lat_idx, 2'b00} : '0;
  assign cm_WriteData  = cm_WriteValid ? way_data[lat_way] : '0;

`ifdef CACHE_PERF_CNT_EN
  // Request outcomes are counted in the IDLE cycle that evaluates them
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      perf_Hits       <= '0;
      perf_Misses     <= '0;
      perf_Writebacks <= '0;
    end else begin
      if (req_hit)  perf_Hits   <= perf_Hits + 32'd1;
      if (req_miss) perf_Misses <= perf_Misses + 32'd1;
      if ((state == ST_WRITEBACK) && cm_WriteReady) perf_Writebacks <= perf_Writebacks + 32'd1;
    end
  end
`endif

endmodule
